// File: rtl/crypt_sched.sv
// crypt_sched: round-robin front end that shares one combinational crypt
// datapath between two requesters. A block is latched onto the datapath,
// dp_enable is held for SETTLE_CYCLES cycles, then the result is captured
// and returned on a valid/ready response port tagged with the requester id.
module crypt_sched #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [9:0]   req0_key,
  input  logic         req0_mode,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [9:0]   req1_key,
  input  logic         req1_mode,
  output logic         dp_enable,
  output logic         dp_mode,
  output logic [127:0] dp_data,
  output logic [9:0]   dp_key,
  input  logic [127:0] dp_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The counter is reloaded only in IDLE and stops at zero, so it cannot wrap.
  localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       last_grant;
  logic [3:0] cnt;
  logic       grant1;
  logic       accept;

  // Round-robin winner: a lone valid port wins; on a tie the port not granted last wins.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid && !grant1;
      req1_ready = grant1;
    end
    accept = req0_ready || req1_ready;
  end

  // Sequencer: accept a block, hold it on the datapath, capture and return the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      dp_enable  <= 1'b0;
      dp_mode    <= 1'b0;
      dp_data    <= '0;
      dp_key     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dp_data    <= grant1 ? req1_data : req0_data;
            dp_key     <= grant1 ? req1_key  : req0_key;
            dp_mode    <= grant1 ? req1_mode : req0_mode;
            rsp_id     <= grant1;
            last_grant <= grant1;
            cnt        <= LOAD;
            dp_enable  <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= dp_result;
            rsp_valid <= 1'b1;
            dp_enable <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_sched.sv
// Testbench for crypt_sched: three instances (settle 2, 1, 15) each driven by a
// behavioural crypt datapath; directed scenarios plus randomized transactions.
module tb_crypt_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         r0v [3], r1v [3], r0r [3], r1r [3];
  logic [127:0] r0d [3], r1d [3];
  logic [9:0]   r0k [3], r1k [3];
  logic         r0m [3], r1m [3];
  logic         en [3], dm [3];
  logic [127:0] dd [3], dr [3];
  logic [9:0]   dk [3];
  logic         rv [3], rr [3];
  logic [127:0] rd [3];
  logic         rid [3], bsy [3];

  int checks = 0;
  int errors = 0;
  bit last_g [3];

  function automatic int sc_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int r);
    logic [15:0] t;
    t = {b, b} << r;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ror8(input logic [7:0] b, input int r);
    logic [15:0] t;
    t = {b, b} >> r;
    return t[7:0];
  endfunction

  // Toy invertible cipher: per-byte key mix, rotate and byte shuffle.
  function automatic logic [127:0] crypt(input logic [127:0] d, input logic [9:0] key, input logic m);
    logic [127:0] o;
    logic [7:0]   kb;
    int           r;
    o = '0;
    r = int'(key[9:8]) + 1;
    for (int k = 0; k < 16; k++) begin
      kb = key[7:0] + 8'(k);
      if (!m) o[8*k +: 8] = rol8(d[8*((k+1)%16) +: 8] ^ kb, r);
      else    o[8*((k+1)%16) +: 8] = ror8(d[8*k +: 8], r) ^ kb;
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    crypt_sched #(.SETTLE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v[g]), .req0_ready(r0r[g]), .req0_data(r0d[g]), .req0_key(r0k[g]), .req0_mode(r0m[g]),
      .req1_valid(r1v[g]), .req1_ready(r1r[g]), .req1_data(r1d[g]), .req1_key(r1k[g]), .req1_mode(r1m[g]),
      .dp_enable(en[g]), .dp_mode(dm[g]), .dp_data(dd[g]), .dp_key(dk[g]), .dp_result(dr[g]),
      .rsp_valid(rv[g]), .rsp_ready(rr[g]), .rsp_data(rd[g]), .rsp_id(rid[g]), .busy(bsy[g])
    );
    assign dr[g] = crypt(dd[g], dk[g], dm[g]);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_ctl"}, {en[i], rv[i], bsy[i], r0r[i], r1r[i], dm[i], rid[i]}, '0);
    chk({tag, "_dd"}, dd[i], '0);
    chk({tag, "_dk"}, dk[i], '0);
    chk({tag, "_rd"}, rd[i], '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0v[i] = 0; r1v[i] = 0; rr[i] = 0;
      r0d[i] = rand128(); r1d[i] = rand128();
      r0k[i] = 10'($urandom); r1k[i] = 10'($urandom);
      r0m[i] = 0; r1m[i] = 0;
      last_g[i] = 1'b1;
    end
    #3;
    for (int i = 0; i < 3; i++) chk_zero(i, "reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with valids driven; checks the grant and consumes the acceptance edge.
  task automatic accept(input int i, output bit w, output logic [127:0] ed, output logic [9:0] ek, output bit em);
    bit v0, v1;
    #1;
    v0 = r0v[i];
    v1 = r1v[i];
    if (v0 && v1) w = !last_g[i];
    else          w = v1;
    chk("ready_pair", {r0r[i], r1r[i]}, w ? 2'b01 : 2'b10);
    ed = w ? r1d[i] : r0d[i];
    ek = w ? r1k[i] : r0k[i];
    em = w ? r1m[i] : r0m[i];
    @(posedge clk);
    last_g[i] = w;
  endtask

  // Runs from just after the acceptance edge to the first IDLE cycle after the response.
  task automatic wait_rsp(input int i, input bit eid, input logic [127:0] ed, input logic [9:0] ek,
                          input bit em, input int hold, output logic [127:0] got);
    int en_cnt = 0;
    int first_rv = 0;
    bit seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (en[i]) en_cnt++;
      if (k == 1) begin
        chk("dp_data", dd[i], ed);
        chk("dp_key", dk[i], ek);
        chk("dp_mode", dm[i], em);
      end
      chk("ready_busy", {r0r[i], r1r[i]}, 2'b00);
      if (rv[i]) begin
        seen = 1;
        first_rv = k;
      end
    end
    chk("rsp_seen", seen, 1);
    chk("rsp_latency", first_rv, sc_of(i) + 1);
    chk("en_width", en_cnt, sc_of(i));
    chk("rsp_id", rid[i], eid);
    chk("rsp_data", rd[i], crypt(ed, ek, em));
    got = rd[i];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_ctl", {rv[i], en[i], r0r[i], r1r[i], rid[i]}, {3'b100, 1'b0, eid});
      chk("hold_data", rd[i], got);
    end
    rr[i] = 1'b1;
    @(posedge clk);
    #1 rr[i] = 1'b0;
    @(negedge clk);
    chk("idle_after", {bsy[i], rv[i]}, 2'b00);
  endtask

  task automatic xact(input int i, input bit v0, input bit v1,
                      input logic [127:0] d0, input logic [9:0] k0, input bit m0,
                      input logic [127:0] d1, input logic [9:0] k1, input bit m1,
                      input int hold, output logic [127:0] got);
    bit w, em;
    logic [127:0] ed;
    logic [9:0] ek;
    r0v[i] = v0; r0d[i] = d0; r0k[i] = k0; r0m[i] = m0;
    r1v[i] = v1; r1d[i] = d1; r1k[i] = k1; r1m[i] = m1;
    accept(i, w, ed, ek, em);
    #1;
    r0v[i] = 0; r1v[i] = 0;
    r0d[i] = rand128(); r1d[i] = rand128();
    r0k[i] = 10'($urandom); r1k[i] = 10'($urandom);
    r0m[i] = 1'($urandom); r1m[i] = 1'($urandom);
    wait_rsp(i, w, ed, ek, em, hold, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] got, got2, blk, ed;
    logic [9:0] ek;
    bit w, em;
    int cnt;

    do_reset();

    // Single decrypt request on port 0.
    xact(0, 1, 0, 128'h000102030405060708090a0b0c0d0e0f, 10'h2A5, 1,
         rand128(), 10'h0, 0, 0, got);

    // Continuous tie: grants must alternate starting at port 0.
    do_reset();
    r0v[0] = 1; r1v[0] = 1;
    for (int n = 0; n < 4; n++) begin
      accept(0, w, ed, ek, em);
      #1;
      if (w) begin r1d[0] = rand128(); r1k[0] = 10'($urandom); r1m[0] = 1'($urandom); end
      else   begin r0d[0] = rand128(); r0k[0] = 10'($urandom); r0m[0] = 1'($urandom); end
      wait_rsp(0, 1'(n % 2), ed, ek, em, 0, got);
    end
    r0v[0] = 0; r1v[0] = 0;

    // Backpressure: request arrives on port 1 while busy and waits.
    r0v[0] = 1; r0d[0] = rand128(); r0k[0] = 10'h133; r0m[0] = 0;
    accept(0, w, ed, ek, em);
    #1;
    r0v[0] = 0; r1v[0] = 1; r1d[0] = rand128(); r1k[0] = 10'h07C; r1m[0] = 1;
    wait_rsp(0, 0, ed, ek, em, 10, got);
    chk("pending_ready1", r1r[0], 1);
    accept(0, w, ed, ek, em);
    #1 r1v[0] = 0;
    wait_rsp(0, 1, ed, ek, em, 0, got);

    // Minimum and maximum settle windows.
    xact(1, 1, 0, rand128(), 10'h155, 0, rand128(), 10'h0, 0, 1, got);
    xact(2, 0, 1, rand128(), 10'h0, 0, rand128(), 10'h3FF, 1, 2, got);

    // Reset in the first RUN cycle discards the block.
    r0v[0] = 1; r0d[0] = rand128(); r0k[0] = 10'h2C3; r0m[0] = 0;
    accept(0, w, ed, ek, em);
    #1 r0v[0] = 0;
    rst = 1'b1;
    #1 chk_zero(0, "midrst");
    for (int i = 0; i < 3; i++) last_g[i] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv[0] || en[0]) cnt++;
    end
    chk("no_rsp_after_rst", cnt, 0);
    xact(0, 1, 1, rand128(), 10'h011, 1, rand128(), 10'h322, 0, 0, got);
    chk("tie_after_rst", got, crypt(got, 10'h0, 0) ^ crypt(got, 10'h0, 0) ^ got);

    // Encrypt then decrypt with the same key restores the block.
    blk = rand128();
    xact(0, 1, 0, blk, 10'h1E7, 0, rand128(), 10'h0, 0, 0, got);
    xact(0, 0, 1, rand128(), 10'h0, 0, got, 10'h1E7, 1, 0, got2);
    chk("roundtrip", got2, blk);

    // Randomized transactions across all three instances.
    for (int n = 0; n < 60; n++) begin
      int i, sel;
      i = $urandom_range(0, 2);
      sel = $urandom_range(1, 3);
      xact(i, sel[0], sel[1], rand128(), 10'($urandom), 1'($urandom),
           rand128(), 10'($urandom), 1'($urandom), $urandom_range(0, 3), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crypt_sched.md
# crypt_sched

Two-port scheduler that shares a single combinational 16-byte crypt datapath (encrypt/decrypt stage chain, 10-bit key) between two requesters. It accepts a block, key and mode from one requester via a valid/ready handshake, arbitrating round-robin when both request. It then holds the operands on the datapath with Enable asserted for a fixed settle window and captures the result into a response register. The result is returned on a valid/ready response port tagged with the requester ID. It sits between the host-side request logic and the Encryptor/Decryptor pair.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles dp_enable is held before the result is captured; legal range 1–15.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester n has a block
- req0_ready / req1_ready  out  1  block accepted when valid&ready on an edge
- req0_data / req1_data  in  128  block; byte k = bits [8k+7:8k], k=0..15 maps a0..a3,b0..b3,c0..c3,d0..d3
- req0_key / req1_key  in  10  round key
- req0_mode / req1_mode  in  1  0 = encrypt, 1 = decrypt
- dp_enable  out  1  Enable to datapath
- dp_mode  out  1  selects encrypt/decrypt result path
- dp_data  out  128  registered operand block
- dp_key  out  10  registered key
- dp_result  in  128  datapath output, same byte packing
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts
- rsp_data  out  128  captured result
- rsp_id  out  1  requester that issued the block
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - The winner is the only valid port, or, if both are valid, the port not granted last (last_grant pointer).
  - The winner's reqN_ready is 1 combinationally; the other ready is 0. No ready is asserted without a valid.
  - On handshake: latch data/key/mode into dp_data/dp_key/dp_mode, latch the ID, update last_grant, load the counter with SETTLE_CYCLES-1, and go to RUN.
- RUN:
  - dp_enable=1.
  - If the counter is nonzero, decrement it.
  - If the counter is 0: capture dp_result into rsp_data and go to DONE.
- DONE:
  - rsp_valid=1 and dp_enable=0.
  - rsp_data and rsp_id are stable until handshake.
  - On rsp_valid&rsp_ready, go to IDLE.
- Both reqN_ready are 0 in RUN and DONE.
- Operands hold their last values outside RUN; dp_enable is the only qualifier.
- Counter is 4 bits; no wrap because it loads only in IDLE and stops at 0.
- Response backpressure is unlimited: DONE holds indefinitely and new requests stall.

## Timing
- Reset (async assert): all outputs 0; rsp_data, dp_data and dp_key are 0; state is IDLE; last_grant=1, so port 0 wins the first tie.
- Reset mid-operation: the in-flight block is discarded and no response is produced.
- Acceptance edge E:
  - dp_enable is high for cycles E+1 .. E+SETTLE_CYCLES.
  - rsp_valid rises in cycle E+SETTLE_CYCLES+1.
- Response handshake edge R: state is IDLE in cycle R+1, and reqN_ready can assert in that cycle.
- Minimum issue interval is SETTLE_CYCLES+2 cycles (SETTLE_CYCLES=2 gives 4).
- Simultaneous valids: alternate grants 0,1,0,1 while both are held high.
- Requests arriving in RUN/DONE are not lost; the requester holds valid until ready.
- reqN_data, key and mode are sampled only at the acceptance edge.

## Test plan
- Reset, then req0 with data=0x000102…0F, key=10'h2A5, mode=1 -> req0_ready in the same cycle, dp_enable high 2 cycles, rsp_valid 3 cycles after acceptance, rsp_id=0, rsp_data = model decrypt result.
- Both valid continuously for 4 blocks -> grant order 0,1,0,1; rsp_id sequence 0,1,0,1; no ready asserted while busy.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_data stable, dp_enable=0, both readys 0; on release, IDLE next cycle.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> dp_enable pulse widths of exactly 1 and 15 cycles; rsp_valid at E+2 and E+16.
- Assert rst in cycle E+1 of RUN -> all outputs 0 immediately; no response emitted; next tie goes to port 0.
- Encrypt with key K followed by decrypt of that result with key K -> second rsp_data equals the original block.
